// File: rtl/qspi_xip_pkg.sv
// Shared types and constants for the QSPI XIP AHB bridge.
package qspi_xip_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = ADDR_W - 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HIT       = 3'd1,
    ST_REQ       = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_FIFO_WAIT = 3'd4,
    ST_RESP      = 3'd5,
    ST_ERR1      = 3'd6,
    ST_ERR2      = 3'd7
  } xip_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Byte address -> word-aligned fetch address.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/qspi_xip_line.sv
// One-entry last-word cache: tag/data/valid with lookup, fill and invalidate.
module qspi_xip_line
  import qspi_xip_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [TAG_W-1:0]  lookup_tag_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              fill_i,
  input  logic [TAG_W-1:0]  fill_tag_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic              inval_i
);

  logic              valid_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] data_q;

  // Fill takes priority over a same-cycle invalidate.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag_i;
      data_q  <= fill_data_i;
    end else if (inval_i) begin
      valid_q <= 1'b0;
    end
  end

  assign hit_o  = valid_q && (tag_q == lookup_tag_i);
  assign data_o = data_q;

endmodule

// File: rtl/qspi_ahb_xip_bridge.sv
// AHB-Lite read-only slave for the QSPI memory-mapped (XIP) window.
module qspi_ahb_xip_bridge
  import qspi_xip_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 1000,
  parameter int unsigned TIMEOUT_W = 10
) (
  input  logic              qspi_clk,
  input  logic              qspi_rst,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              hready_in,
  output logic [DATA_W-1:0] hrdata,
  output logic              hreadyout,
  output logic              hresp,
  input  logic              qspi_mode,
  input  logic              qspi_en,
  input  logic              cache_flush,
  output logic              memory_mapped_mode_req,
  output logic [ADDR_W-1:0] memory_mapped_mode_addr,
  input  logic              qspi_busy,
  input  logic              qspi_done,
  input  logic              rx_fifo_empty,
  input  logic [DATA_W-1:0] rx_fifo_read_data,
  output logic              rx_fifo_read
);

  xip_state_e           state_q, state_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    hrdata_q, hrdata_d;
  logic                 req_q, req_d;
  logic                 hreadyout_q, hreadyout_d;
  logic                 hresp_q, hresp_d;

  logic                 mm_on_c, accept_c, waiting_c, pop_c, timeout_c, inval_c;
  logic                 line_hit;
  logic [DATA_W-1:0]    line_data;
  logic                 unused_inputs;

  // Size and sub-word address bits do not matter: the whole word is returned.
  assign unused_inputs = ^{hsize, haddr[1:0], htrans[0]};

  assign mm_on_c   = qspi_mode & qspi_en;
  assign accept_c  = hsel & htrans[1] & hready_in & hreadyout_q;
  assign waiting_c = state_q inside {ST_REQ, ST_WAIT_DONE, ST_FIFO_WAIT};
  assign pop_c     = (state_q == ST_FIFO_WAIT) && !rx_fifo_empty;
  assign timeout_c = waiting_c && (tmo_q == TIMEOUT_W'(TIMEOUT - 1)) && !pop_c;
  assign inval_c   = cache_flush | ~mm_on_c | timeout_c;

  qspi_xip_line u_line (
    .clk_i        (qspi_clk),
    .rst_i        (qspi_rst),
    .lookup_tag_i (haddr[ADDR_W-1:2]),
    .hit_o        (line_hit),
    .data_o       (line_data),
    .fill_i       (pop_c),
    .fill_tag_i   (addr_q[ADDR_W-1:2]),
    .fill_data_i  (rx_fifo_read_data),
    .inval_i      (inval_c)
  );

  // State register plus datapath and registered AHB/request outputs.
  always_ff @(posedge qspi_clk) begin
    if (qspi_rst) begin
      state_q     <= ST_IDLE;
      tmo_q       <= '0;
      addr_q      <= '0;
      hrdata_q    <= '0;
      req_q       <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      addr_q      <= addr_d;
      hrdata_q    <= hrdata_d;
      req_q       <= req_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  // Next-state decode; a new transfer is only accepted from a ready data phase.
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    addr_d   = addr_q;
    hrdata_d = hrdata_q;

    unique case (state_q)
      ST_IDLE, ST_HIT, ST_RESP, ST_ERR2: state_d = ST_IDLE;
      ST_REQ: begin
        if (qspi_done)      state_d = ST_FIFO_WAIT;
        else if (qspi_busy) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: if (qspi_done) state_d = ST_FIFO_WAIT;
      ST_FIFO_WAIT: begin
        if (pop_c) begin
          state_d  = ST_RESP;
          hrdata_d = rx_fifo_read_data;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase

    if (waiting_c) tmo_d = tmo_q + TIMEOUT_W'(1);
    if (timeout_c) state_d = ST_ERR1;

    if (accept_c) begin
      if (hwrite || !mm_on_c) begin
        state_d = ST_ERR1;
      end else if (line_hit) begin
        state_d  = ST_HIT;
        hrdata_d = line_data;
      end else begin
        state_d = ST_REQ;
        addr_d  = word_align(haddr);
        tmo_d   = '0;
      end
    end
  end

  // Output decode from the upcoming state so the ports come straight off flops.
  always_comb begin
    req_d       = 1'b0;
    hreadyout_d = 1'b1;
    hresp_d     = HRESP_OKAY;
    if (state_d == ST_REQ) req_d = 1'b1;
    if (state_d inside {ST_REQ, ST_WAIT_DONE, ST_FIFO_WAIT, ST_ERR1}) hreadyout_d = 1'b0;
    if (state_d inside {ST_ERR1, ST_ERR2}) hresp_d = HRESP_ERROR;
  end

  assign hrdata                  = hrdata_q;
  assign hreadyout               = hreadyout_q;
  assign hresp                   = hresp_q;
  assign memory_mapped_mode_req  = req_q;
  assign memory_mapped_mode_addr = addr_q;
  // Pop is combinational so it lines up with the first-word-fall-through head.
  assign rx_fifo_read            = pop_c;

endmodule

// File: tb/tb_qspi_ahb_xip_bridge.sv
// Self-checking bench for qspi_ahb_xip_bridge against a transaction-level cache model.
module tb_qspi_ahb_xip_bridge;

  localparam int unsigned TMO = 16;

  logic        qspi_clk, qspi_rst;
  logic        hsel, hwrite, hready_in;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr, hrdata;
  logic        hreadyout, hresp;
  logic        qspi_mode, qspi_en, cache_flush;
  logic        memory_mapped_mode_req;
  logic [31:0] memory_mapped_mode_addr;
  logic        qspi_busy, qspi_done, rx_fifo_empty, rx_fifo_read;
  logic [31:0] rx_fifo_read_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one cached word.
  bit          m_valid;
  logic [29:0] m_tag;
  logic [31:0] m_data;

  qspi_ahb_xip_bridge #(.TIMEOUT(TMO), .TIMEOUT_W(5)) dut (
    .qspi_clk                (qspi_clk),
    .qspi_rst                (qspi_rst),
    .hsel                    (hsel),
    .htrans                  (htrans),
    .hwrite                  (hwrite),
    .hsize                   (hsize),
    .haddr                   (haddr),
    .hready_in               (hready_in),
    .hrdata                  (hrdata),
    .hreadyout               (hreadyout),
    .hresp                   (hresp),
    .qspi_mode               (qspi_mode),
    .qspi_en                 (qspi_en),
    .cache_flush             (cache_flush),
    .memory_mapped_mode_req  (memory_mapped_mode_req),
    .memory_mapped_mode_addr (memory_mapped_mode_addr),
    .qspi_busy               (qspi_busy),
    .qspi_done               (qspi_done),
    .rx_fifo_empty           (rx_fifo_empty),
    .rx_fifo_read_data       (rx_fifo_read_data),
    .rx_fifo_read            (rx_fifo_read)
  );

  initial begin
    qspi_clk = 1'b0;
    forever #5 qspi_clk = ~qspi_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge qspi_clk);
    #1;
  endtask

  task automatic ahb_read(input logic [31:0] a, input logic [31:0] word, input int dly, input bit use_busy);
    bit exp_err, exp_hit, exp_req;
    exp_err = !(qspi_mode && qspi_en);
    exp_hit = !exp_err && m_valid && (m_tag == a[31:2]);
    hsel = 1'b1; htrans = (($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11);
    hwrite = 1'b0; haddr = a; hsize = 3'($urandom_range(0, 2));
    cyc();
    hsel = 1'b0; htrans = 2'b00;
    if (exp_err) begin
      m_valid = 1'b0;
      n_checks++; if ({hreadyout, hresp, memory_mapped_mode_req} !== 3'b010) begin n_fail++;
        $display("FAIL rd_err1 a=%h: got rdy/resp/req=%b expected 010", a, {hreadyout, hresp, memory_mapped_mode_req}); end
      cyc();
      n_checks++; if ({hreadyout, hresp, memory_mapped_mode_req} !== 3'b110) begin n_fail++;
        $display("FAIL rd_err2 a=%h: got rdy/resp/req=%b expected 110", a, {hreadyout, hresp, memory_mapped_mode_req}); end
      cyc();
      n_checks++; if ({hreadyout, hresp} !== 2'b10) begin n_fail++;
        $display("FAIL rd_err_idle a=%h: got rdy/resp=%b expected 10", a, {hreadyout, hresp}); end
    end else if (exp_hit) begin
      n_checks++; if ({hreadyout, hresp, memory_mapped_mode_req, rx_fifo_read} !== 4'b1000) begin n_fail++;
        $display("FAIL hit_ctrl a=%h: got rdy/resp/req/pop=%b expected 1000", a, {hreadyout, hresp, memory_mapped_mode_req, rx_fifo_read}); end
      n_checks++; if (hrdata !== m_data) begin n_fail++;
        $display("FAIL hit_data a=%h: got %h expected %h", a, hrdata, m_data); end
      cyc();
    end else begin
      n_checks++; if (memory_mapped_mode_req !== 1'b1 || memory_mapped_mode_addr !== {a[31:2], 2'b00}) begin n_fail++;
        $display("FAIL miss_req a=%h: got req=%b addr=%h expected req=1 addr=%h", a, memory_mapped_mode_req, memory_mapped_mode_addr, {a[31:2], 2'b00}); end
      for (int k = 0; k <= dly; k++) begin
        qspi_busy = use_busy && (k == 0);
        qspi_done = (k == dly);
        if (k == dly) begin rx_fifo_empty = 1'b0; rx_fifo_read_data = word; end
        exp_req = (k == 0) || !use_busy;
        n_checks++; if ({hreadyout, rx_fifo_read, memory_mapped_mode_req} !== {1'b0, 1'b0, exp_req}) begin n_fail++;
          $display("FAIL miss_stall k=%0d: got rdy/pop/req=%b expected 00%b", k, {hreadyout, rx_fifo_read, memory_mapped_mode_req}, exp_req); end
        cyc();
      end
      qspi_busy = 1'b0; qspi_done = 1'b0;
      n_checks++; if ({rx_fifo_read, hreadyout, memory_mapped_mode_req} !== 3'b100) begin n_fail++;
        $display("FAIL miss_pop a=%h: got pop/rdy/req=%b expected 100", a, {rx_fifo_read, hreadyout, memory_mapped_mode_req}); end
      cyc();
      rx_fifo_empty = 1'b1; rx_fifo_read_data = $urandom();
      n_checks++; if ({hreadyout, hresp, rx_fifo_read} !== 3'b100 || hrdata !== word) begin n_fail++;
        $display("FAIL miss_resp a=%h: got rdy/resp/pop=%b data=%h expected 100 data=%h", a, {hreadyout, hresp, rx_fifo_read}, hrdata, word); end
      m_valid = 1'b1; m_tag = a[31:2]; m_data = word;
      cyc();
    end
  endtask

  task automatic ahb_write(input logic [31:0] a);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = a;
    cyc();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    n_checks++; if ({hreadyout, hresp, memory_mapped_mode_req} !== 3'b010) begin n_fail++;
      $display("FAIL wr_err1 a=%h: got rdy/resp/req=%b expected 010", a, {hreadyout, hresp, memory_mapped_mode_req}); end
    cyc();
    n_checks++; if ({hreadyout, hresp, memory_mapped_mode_req} !== 3'b110) begin n_fail++;
      $display("FAIL wr_err2 a=%h: got rdy/resp/req=%b expected 110", a, {hreadyout, hresp, memory_mapped_mode_req}); end
    cyc();
  endtask

  task automatic test_reset();
    n_checks++; if (hrdata !== 32'h0 || memory_mapped_mode_addr !== 32'h0) begin n_fail++;
      $display("FAIL reset_data: got hrdata=%h addr=%h expected 0/0", hrdata, memory_mapped_mode_addr); end
    n_checks++; if ({hreadyout, hresp, memory_mapped_mode_req, rx_fifo_read} !== 4'b1000) begin n_fail++;
      $display("FAIL reset_ctrl: got rdy/resp/req/pop=%b expected 1000", {hreadyout, hresp, memory_mapped_mode_req, rx_fifo_read}); end
    qspi_rst = 1'b0;
    m_valid = 1'b0;
    cyc();
  endtask

  task automatic test_idle_and_stray_done();
    hsel = 1'b1; htrans = 2'b00; haddr = 32'h104;
    qspi_done = 1'b1; rx_fifo_empty = 1'b0; rx_fifo_read_data = 32'h1234_5678;
    n_checks++; if (rx_fifo_read !== 1'b0) begin n_fail++;
      $display("FAIL stray_done_pop: got %b expected 0", rx_fifo_read); end
    cyc();
    hsel = 1'b0; qspi_done = 1'b0; rx_fifo_empty = 1'b1;
    n_checks++; if ({hreadyout, hresp, memory_mapped_mode_req} !== 3'b100) begin n_fail++;
      $display("FAIL idle_trans: got rdy/resp/req=%b expected 100", {hreadyout, hresp, memory_mapped_mode_req}); end
  endtask

  task automatic test_miss_hit();
    ahb_read(32'h0000_0104, 32'hDEAD_BEEF, 0, 1'b0);
    ahb_read(32'h0000_0106, 32'h0, 0, 1'b0);
    ahb_read(32'h0000_0208, 32'hCAFE_0001, 4, 1'b1);
    ahb_read(32'h0000_020B, 32'h0, 0, 1'b0);
  endtask

  task automatic test_error();
    ahb_write(32'h0000_0208);
    ahb_read(32'h0000_0208, 32'h0, 0, 1'b0);
    qspi_mode = 1'b0;
    ahb_read(32'h0000_0208, 32'h0, 0, 1'b0);
    qspi_mode = 1'b1;
    ahb_read(32'h0000_0208, 32'h0BAD_F00D, 1, 1'b0);
    qspi_en = 1'b0;
    ahb_read(32'h0000_0208, 32'h0, 0, 1'b0);
    qspi_en = 1'b1;
    ahb_read(32'h0000_0208, 32'h5A5A_A5A5, 2, 1'b1);
  endtask

  task automatic test_timeout();
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0000_3000;
    cyc();
    hsel = 1'b0; htrans = 2'b00;
    for (int k = 0; k < int'(TMO); k++) begin
      n_checks++; if ({hreadyout, hresp, memory_mapped_mode_req} !== 3'b001) begin n_fail++;
        $display("FAIL tmo_stall k=%0d: got rdy/resp/req=%b expected 001", k, {hreadyout, hresp, memory_mapped_mode_req}); end
      cyc();
    end
    n_checks++; if ({hreadyout, hresp, memory_mapped_mode_req} !== 3'b010) begin n_fail++;
      $display("FAIL tmo_err1: got rdy/resp/req=%b expected 010", {hreadyout, hresp, memory_mapped_mode_req}); end
    cyc();
    n_checks++; if ({hreadyout, hresp, memory_mapped_mode_req} !== 3'b110) begin n_fail++;
      $display("FAIL tmo_err2: got rdy/resp/req=%b expected 110", {hreadyout, hresp, memory_mapped_mode_req}); end
    cyc();
    m_valid = 1'b0;
    ahb_read(32'h0000_3000, 32'h7777_1111, 3, 1'b0);
    ahb_read(32'h0000_3001, 32'h0, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0000_2000;
    cyc();
    hsel = 1'b0; htrans = 2'b00;
    qspi_busy = 1'b1;
    cyc();
    qspi_busy = 1'b0;
    n_checks++; if ({hreadyout, memory_mapped_mode_req} !== 2'b00) begin n_fail++;
      $display("FAIL rstmid_wait: got rdy/req=%b expected 00", {hreadyout, memory_mapped_mode_req}); end
    qspi_rst = 1'b1;
    cyc();
    qspi_rst = 1'b0;
    m_valid = 1'b0;
    n_checks++; if ({hreadyout, hresp, memory_mapped_mode_req} !== 3'b100 || hrdata !== 32'h0) begin n_fail++;
      $display("FAIL rstmid_idle: got rdy/resp/req=%b data=%h expected 100 data=0", {hreadyout, hresp, memory_mapped_mode_req}, hrdata); end
    ahb_read(32'h0000_0104, 32'h1357_9BDF, 1, 1'b0);
  endtask

  task automatic test_flush();
    ahb_read(32'h0000_0400, 32'hF1F1_0400, 2, 1'b0);
    ahb_read(32'h0000_0400, 32'h0, 0, 1'b0);
    cache_flush = 1'b1;
    cyc();
    cache_flush = 1'b0;
    m_valid = 1'b0;
    ahb_read(32'h0000_0402, 32'hF2F2_0400, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] w2;
    ahb_read(32'h0000_0500, 32'hAAAA_0500, 1, 1'b0);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0000_0500;
    cyc();
    n_checks++; if (hreadyout !== 1'b1 || hrdata !== m_data) begin n_fail++;
      $display("FAIL b2b_hit1: got rdy=%b data=%h expected 1 data=%h", hreadyout, hrdata, m_data); end
    htrans = 2'b11; haddr = 32'h0000_0502;
    cyc();
    n_checks++; if (hreadyout !== 1'b1 || hrdata !== m_data || memory_mapped_mode_req !== 1'b0) begin n_fail++;
      $display("FAIL b2b_hit2: got rdy=%b req=%b data=%h expected 1/0 data=%h", hreadyout, memory_mapped_mode_req, hrdata, m_data); end
    htrans = 2'b10; haddr = 32'h0000_0600;
    cyc();
    hsel = 1'b0; htrans = 2'b00;
    n_checks++; if ({hreadyout, memory_mapped_mode_req} !== 2'b01 || memory_mapped_mode_addr !== 32'h0000_0600) begin n_fail++;
      $display("FAIL b2b_miss: got rdy/req=%b addr=%h expected 01 addr=00000600", {hreadyout, memory_mapped_mode_req}, memory_mapped_mode_addr); end
    w2 = $urandom();
    qspi_done = 1'b1; qspi_busy = 1'b1; rx_fifo_empty = 1'b0; rx_fifo_read_data = w2;
    cyc();
    qspi_done = 1'b0; qspi_busy = 1'b0;
    n_checks++; if (rx_fifo_read !== 1'b1) begin n_fail++;
      $display("FAIL b2b_pop: got %b expected 1", rx_fifo_read); end
    cyc();
    rx_fifo_empty = 1'b1;
    n_checks++; if (hreadyout !== 1'b1 || hrdata !== w2) begin n_fail++;
      $display("FAIL b2b_resp: got rdy=%b data=%h expected 1 data=%h", hreadyout, hrdata, w2); end
    m_valid = 1'b1; m_tag = 30'h0000_0600 >> 2; m_data = w2;
    cyc();
    ahb_read(32'h0000_0603, 32'h0, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] pool [4];
    logic [31:0] a;
    int r;
    pool[0] = 32'h0000_0104; pool[1] = 32'h0000_0200;
    pool[2] = 32'h0000_03FC; pool[3] = 32'h0001_0000;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      a = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
      case (r)
        0: ahb_write(a);
        1: begin
          cache_flush = 1'b1; cyc(); cache_flush = 1'b0; m_valid = 1'b0;
        end
        2: begin
          if ($urandom_range(0, 1) == 0) qspi_mode = 1'b0; else qspi_en = 1'b0;
          ahb_read(a, 32'h0, 0, 1'b0);
          qspi_mode = 1'b1; qspi_en = 1'b1;
        end
        default: ahb_read(a, $urandom(), $urandom_range(0, 8), 1'($urandom_range(0, 1)));
      endcase
    end
  endtask

  initial begin
    qspi_rst = 1'b1; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2;
    haddr = 32'h0; hready_in = 1'b1; qspi_mode = 1'b1; qspi_en = 1'b1;
    cache_flush = 1'b0; qspi_busy = 1'b0; qspi_done = 1'b0;
    rx_fifo_empty = 1'b1; rx_fifo_read_data = 32'h0;
    m_valid = 1'b0; m_tag = '0; m_data = '0;
    cyc(); cyc();
    test_reset();
    test_idle_and_stray_done();
    test_miss_hit();
    test_error();
    test_timeout();
    test_reset_mid();
    test_flush();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qspi_ahb_xip_bridge.md
# qspi_ahb_xip_bridge

- AHB-Lite read-only slave for the QSPI memory-mapped (XIP) region, located directly upstream of `protocol_controller`.
- Turns each AHB read into a memory-mapped request, waits for `qspi_done`, pops one word from the RX FIFO and returns it on `hrdata` with wait states.
- Holds a one-entry last-word cache, so a repeated read of the same word completes with zero wait states.
- Writes, and reads made while memory-mapped mode is disabled, get a two-cycle AHB ERROR.

## Interface
Parameters:
- `TIMEOUT`, 1000: cycles allowed from request issue to FIFO data before ERROR.
- `TIMEOUT_W`, 10: width of the timeout counter (must hold `TIMEOUT`).

Ports:
- `qspi_clk` in 1: sole clock (AHB runs on the same clock).
- `qspi_rst` in 1: reset, synchronous, active-high.
- `hsel` in 1, `htrans` in 2, `hwrite` in 1, `hsize` in 3, `haddr` in 32, `hready_in` in 1: AHB-Lite address phase.
- `hrdata` out 32, `hreadyout` out 1, `hresp` out 1: AHB-Lite data phase.
- `qspi_mode` in 1: 1 = memory-mapped mode selected.
- `qspi_en` in 1: controller enable.
- `cache_flush` in 1: one-cycle pulse that invalidates the cache.
- `memory_mapped_mode_req` out 1: request to `protocol_controller`.
- `memory_mapped_mode_addr` out 32: word-aligned fetch address.
- `qspi_busy` in 1, `qspi_done` in 1: status from `protocol_controller`; `qspi_done` is a one-cycle pulse.
- `rx_fifo_empty` in 1: RX FIFO empty flag.
- `rx_fifo_read_data` in 32: RX FIFO head word; first-word-fall-through, valid whenever `!rx_fifo_empty`.
- `rx_fifo_read` out 1: one-cycle pop.

## Operation
- Transfer accepted when `hsel & htrans[1] & hready_in & hreadyout` (NONSEQ/SEQ).
- IDLE/BUSY transfers, or `hsel`=0, get OKAY with zero wait states.
- Decode order at accept:
  - `hwrite`=1 → ERR1.
  - Else `!(qspi_mode & qspi_en)` → ERR1.
  - Else hit (cache valid and `haddr[31:2]` == tag) → HIT.
  - Else miss → REQ, latch `{haddr[31:2],2'b00}` into `memory_mapped_mode_addr`.
- `hsize` is ignored: the full word is always returned and the master selects byte lanes.
- States:
  - IDLE: `hreadyout`=1.
  - HIT: one data-phase cycle with `hrdata`=cache data, `hreadyout`=1, then IDLE, or straight into the next decode if another transfer is accepted in the same cycle.
  - REQ: `memory_mapped_mode_req`=1. Leave when `qspi_busy`=1 → WAIT_DONE, or when `qspi_done`=1 → FIFO_WAIT.
  - WAIT_DONE: req=0. On `qspi_done` → FIFO_WAIT.
  - FIFO_WAIT: when `!rx_fifo_empty`, pulse `rx_fifo_read`, capture `rx_fifo_read_data` into `hrdata` and the cache, set the tag and valid bit → RESP.
  - RESP: `hreadyout`=1, `hresp`=0 for one cycle → IDLE.
  - ERR1: `hreadyout`=0, `hresp`=1 → ERR2.
  - ERR2: `hreadyout`=1, `hresp`=1 → IDLE.
- `hreadyout`=0 in REQ, WAIT_DONE, FIFO_WAIT and ERR1.
- Timeout:
  - Counter clears on entering REQ and increments each cycle in REQ, WAIT_DONE and FIFO_WAIT.
  - When it reaches `TIMEOUT-1` with no pop in that cycle → ERR1; req drops and the cache is not updated.
- Cache invalidate sources:
  - `cache_flush`.
  - `qspi_en`=0.
  - `qspi_mode`=0.
  - A timeout error.
- If invalidate and fill happen in the same cycle, the fill wins.

## Timing
- Reset values:
  - Outputs: `hrdata`=0, `hreadyout`=1, `hresp`=0, `memory_mapped_mode_req`=0, `memory_mapped_mode_addr`=0, `rx_fifo_read`=0.
  - Internal: state IDLE, cache invalid, timeout counter 0.
- Hit: accept in cycle T0; data with `hreadyout`=1 in T1. Zero wait states.
- Miss:
  - Accept in T0; REQ with req=1 from T1.
  - `qspi_done` at Td.
  - If the FIFO is non-empty at Td+1: pop at Td+1, RESP at Td+2.
- `memory_mapped_mode_addr` is stable from T1 until the next miss accept.
- `qspi_busy` and `qspi_done` in the same REQ cycle → FIFO_WAIT (done dominates).
- `qspi_done` seen outside REQ/WAIT_DONE is ignored.
- Reset mid-transfer: state returns to IDLE on the next edge and req deasserts in that same cycle.

## Structure
- Shared package `qspi_xip_pkg` holds:
  - The state enum (IDLE, HIT, REQ, WAIT_DONE, FIFO_WAIT, RESP, ERR1, ERR2).
  - `HTRANS_IDLE/BUSY/NONSEQ/SEQ`.
  - `HRESP_OKAY/ERROR`.
- One sub-module, `qspi_xip_line`: the one-entry tag/data/valid register with lookup, fill and invalidate ports.

## Test plan
- Miss: read 0x0000_0104 with mode=1, en=1 → req=1 at T1, addr=0x0000_0104. After `qspi_done` plus FIFO word 0xDEADBEEF → one `rx_fifo_read` pulse and `hrdata`=0xDEADBEEF with `hreadyout`=1 two cycles after done.
- Hit: read 0x0000_0106 next → zero wait states, `hrdata`=0xDEADBEEF, no req and no FIFO pop.
- Error: a write, then a read with `qspi_mode`=0 → each gets `hreadyout`=0/`hresp`=1, then `hreadyout`=1/`hresp`=1. No req. Cache invalidated by `qspi_mode`=0.
- Timeout: `TIMEOUT`=16, `qspi_done` never arrives → two-cycle ERROR after 16 stall cycles, req=0, a following read of the same address misses.
- Reset and flush:
  - Assert `qspi_rst` in WAIT_DONE → next cycle `hreadyout`=1, req=0, state IDLE.
  - `cache_flush` pulsed after a fill → the same address misses.
